// File: rtl/aplic_lat_pkg.sv
// Shared types and constants for the APLIC interrupt latency monitor.
// Widths here match the default top-level parameters.
package aplic_lat_pkg;

  localparam int LAT_CNT_W = 32;
  localparam int LAT_SUM_W = 48;

  localparam logic [15:0] SAMPLES_MAX = 16'hFFFF;
  localparam logic [LAT_CNT_W-1:0] CNT_ALL_ONES = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_RUN,
    ST_STOP,
    ST_CAPTURE,
    ST_RSTC
  } lat_state_e;

  typedef struct packed {
    logic [LAT_CNT_W-1:0] last;
    logic [LAT_CNT_W-1:0] min;
    logic [LAT_CNT_W-1:0] max;
    logic [LAT_SUM_W-1:0] sum;
    logic [15:0]          samples;
    logic [15:0]          abandon;
  } lat_stats_t;

endpackage

// File: rtl/aplic_lat_stats.sv
// Latency statistics: last/min/max, saturating sum and counters.
// A clear in the same cycle as a commit discards the sample.
module aplic_lat_stats
  import aplic_lat_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 commit_i,
  input  logic                 abandon_i,
  input  logic [LAT_CNT_W-1:0] val_i,
  output lat_stats_t           stats_o,
  output logic                 valid_o
);

  logic [LAT_CNT_W-1:0] last_q, min_q, max_q;
  logic [LAT_SUM_W-1:0] sum_q;
  logic [15:0]          samples_q, abandon_q;
  logic                 valid_q;
  logic [LAT_SUM_W:0]   sum_ext;

  assign sum_ext = {1'b0, sum_q} + (LAT_SUM_W+1)'(val_i);

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      last_q    <= '0;
      min_q     <= '1;
      max_q     <= '0;
      sum_q     <= '0;
      samples_q <= '0;
      abandon_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= commit_i;
      if (commit_i) begin
        last_q <= val_i;
        if (val_i < min_q) min_q <= val_i;
        if (val_i > max_q) max_q <= val_i;
        sum_q <= sum_ext[LAT_SUM_W] ? '1
                                    : sum_ext[LAT_SUM_W-1:0];
        if (samples_q != SAMPLES_MAX)
          samples_q <= samples_q + 16'd1;
      end
      if (abandon_i && abandon_q != SAMPLES_MAX)
        abandon_q <= abandon_q + 16'd1;
    end
  end

  assign stats_o = '{last: last_q, min: min_q, max: max_q,
                     sum: sum_q, samples: samples_q,
                     abandon: abandon_q};
  assign valid_o = valid_q;

endmodule

// File: rtl/aplic_lat_monitor.sv
// Interrupt latency monitor: arms on a pending edge of one source,
// drives the cycle counter and samples it when the claim arrives.
module aplic_lat_monitor
  import aplic_lat_pkg::*;
#(
  parameter int NR_SRC = 32,
  parameter int CNT_W  = LAT_CNT_W,
  parameter int SUM_W  = LAT_SUM_W,
  parameter int SETTLE = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      enable_i,
  input  logic [$clog2(NR_SRC)-1:0] src_sel_i,
  input  logic [NR_SRC-1:0]         pend_i,
  input  logic                      claim_valid_i,
  input  logic [$clog2(NR_SRC)-1:0] claim_id_i,
  input  logic                      clear_i,
  input  logic [CNT_W-1:0]          cnt_val_i,
  output logic                      cnt_start_o,
  output logic                      cnt_stop_o,
  output logic                      cnt_rst_o,
  output logic                      busy_o,
  output logic                      sample_valid_o,
  output logic [CNT_W-1:0]          last_o,
  output logic [CNT_W-1:0]          min_o,
  output logic [CNT_W-1:0]          max_o,
  output logic [SUM_W-1:0]          sum_o,
  output logic [15:0]               samples_o,
  output logic [15:0]               abandon_o,
  output logic                      overflow_o
);

  localparam int SEL_W = $clog2(NR_SRC);
  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  lat_state_e       state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic             prev_q, prev_d;
  logic             ovf_q, ovf_d;
  logic             start_q, stop_q, crst_q, busy_q;
  logic             pend_sel, commit, abandon;
  lat_stats_t       stats;

  assign pend_sel = pend_i[sel_q];

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    prev_d   = prev_q;
    settle_d = settle_q;
    ovf_d    = clear_i ? 1'b0 : ovf_q;
    commit   = 1'b0;
    abandon  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (enable_i) state_d = ST_RSTC;
      end
      ST_RSTC: begin
        if (enable_i) begin
          state_d = ST_ARMED;
          sel_d   = src_sel_i;
          prev_d  = pend_i[src_sel_i];
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARMED: begin
        prev_d = pend_sel;
        if (!enable_i) state_d = ST_RSTC;
        else if (sel_q != '0 && pend_sel && !prev_q)
          state_d = ST_RUN;
      end
      ST_RUN: begin
        prev_d = pend_sel;
        if (!enable_i) begin
          state_d = ST_RSTC;
        end else if (cnt_val_i == CNT_ALL_ONES) begin
          ovf_d   = 1'b1;
          state_d = ST_RSTC;
        end else if (claim_valid_i && claim_id_i == sel_q) begin
          state_d  = ST_STOP;
          settle_d = '0;
        end else if (!pend_sel && prev_q) begin
          abandon = 1'b1;
          state_d = ST_RSTC;
        end
      end
      ST_STOP: begin
        if (!enable_i) state_d = ST_RSTC;
        else if (settle_q == SET_W'(SETTLE - 1))
          state_d = ST_CAPTURE;
        else settle_d = settle_q + 1'b1;
      end
      ST_CAPTURE: begin
        state_d = ST_RSTC;
        commit  = enable_i;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control outputs are decoded from the next state so they line up
  // with the registered state.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      settle_q <= '0;
      prev_q   <= 1'b0;
      ovf_q    <= 1'b0;
      start_q  <= 1'b0;
      stop_q   <= 1'b0;
      crst_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      settle_q <= settle_d;
      prev_q   <= prev_d;
      ovf_q    <= ovf_d;
      start_q  <= state_d == ST_RUN || state_d == ST_STOP;
      stop_q   <= state_d == ST_STOP;
      crst_q   <= state_d == ST_RSTC;
      busy_q   <= state_d == ST_RUN || state_d == ST_STOP ||
                  state_d == ST_CAPTURE;
    end
  end

  aplic_lat_stats u_stats (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (clear_i),
    .commit_i  (commit),
    .abandon_i (abandon),
    .val_i     (cnt_val_i),
    .stats_o   (stats),
    .valid_o   (sample_valid_o)
  );

  assign cnt_start_o = start_q;
  assign cnt_stop_o  = stop_q;
  assign cnt_rst_o   = crst_q;
  assign busy_o      = busy_q;
  assign overflow_o  = ovf_q;
  assign last_o      = stats.last;
  assign min_o       = stats.min;
  assign max_o       = stats.max;
  assign sum_o       = stats.sum;
  assign samples_o   = stats.samples;
  assign abandon_o   = stats.abandon;

endmodule

// File: tb/tb_aplic_lat_monitor.sv
// Self-checking bench for aplic_lat_monitor: measurement table plus
// hand-written corner sequences, with a sample scoreboard.
module tb_aplic_lat_monitor;

  localparam int K_NORM   = 0;
  localparam int K_ABAN   = 1;
  localparam int K_OVF    = 2;
  localparam int K_CLEAR  = 3;
  localparam int K_CLRCAP = 4;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        enable;
  logic [4:0]  src_sel;
  logic [31:0] pend;
  logic        claim_valid;
  logic [4:0]  claim_id;
  logic        clear;
  logic [31:0] cval;
  logic        cnt_start_o, cnt_stop_o, cnt_rst_o, busy_o;
  logic        sample_valid_o, overflow_o;
  logic [31:0] last_o, min_o, max_o;
  logic [47:0] sum_o;
  logic [15:0] samples_o, abandon_o;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  aplic_lat_monitor dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .enable_i       (enable),
    .src_sel_i      (src_sel),
    .pend_i         (pend),
    .claim_valid_i  (claim_valid),
    .claim_id_i     (claim_id),
    .clear_i        (clear),
    .cnt_val_i      (cval),
    .cnt_start_o    (cnt_start_o),
    .cnt_stop_o     (cnt_stop_o),
    .cnt_rst_o      (cnt_rst_o),
    .busy_o         (busy_o),
    .sample_valid_o (sample_valid_o),
    .last_o         (last_o),
    .min_o          (min_o),
    .max_o          (max_o),
    .sum_o          (sum_o),
    .samples_o      (samples_o),
    .abandon_o      (abandon_o),
    .overflow_o     (overflow_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_ni === 1'b1 && sample_valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_sample", 64'(last_o), 64'hDEAD);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("sb_last", 64'(last_o), 64'(e));
      end
    end
  end

  typedef struct {
    int          kind;
    logic [31:0] val;
    logic [31:0] e_last, e_min, e_max;
    logic [47:0] e_sum;
    logic [15:0] e_smp, e_ab;
    logic        e_ovf;
  } vec_t;

  vec_t tbl[8];

  task automatic wait_start();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cnt_start_o) return;
    end
    check("start_timeout", 64'd0, 64'd1);
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_meas(input int kind, input logic [31:0] val);
    bit seen;
    case (kind)
      K_NORM: begin
        pend[5] = 1'b1;
        wait_start();
        claim_valid = 1'b1; claim_id = 5'd7;
        @(negedge clk);
        claim_id = 5'd5; cval = val;
        exp_q.push_back(val);
        @(negedge clk);
        claim_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
          @(negedge clk);
          seen = sample_valid_o;
        end
        check("norm_valid_seen", 64'(seen), 64'd1);
        check("norm_rst_pulse", 64'(cnt_rst_o), 64'd1);
        pend[5] = 1'b0; cval = '0;
        @(negedge clk);
        check("norm_rst_once", 64'(cnt_rst_o), 64'd0);
        settle(3);
      end
      K_ABAN: begin
        pend[5] = 1'b1;
        wait_start();
        claim_valid = 1'b1; claim_id = 5'd7;
        @(negedge clk);
        check("aban_still_run", 64'(cnt_start_o), 64'd1);
        claim_valid = 1'b0; pend[5] = 1'b0;
        @(negedge clk);
        check("aban_rst_pulse", 64'(cnt_rst_o), 64'd1);
        settle(3);
      end
      K_OVF: begin
        pend[5] = 1'b1;
        wait_start();
        cval = '1;
        @(negedge clk);
        cval = '0;
        check("ovf_rst_pulse", 64'(cnt_rst_o), 64'd1);
        pend[5] = 1'b0;
        settle(3);
      end
      K_CLEAR: begin
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        settle(1);
      end
      default: begin
        pend[5] = 1'b1;
        wait_start();
        claim_valid = 1'b1; claim_id = 5'd5; cval = val;
        @(negedge clk);
        claim_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
          if (busy_o && !cnt_start_o) break;
          @(negedge clk);
        end
        check("clrcap_in_capture", 64'(busy_o && !cnt_start_o),
              64'd1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clrcap_no_valid", 64'(sample_valid_o), 64'd0);
        pend[5] = 1'b0; cval = '0;
        settle(3);
      end
    endcase
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_start"}, 64'(cnt_start_o), 64'd0);
    check({tag, "_stop"}, 64'(cnt_stop_o), 64'd0);
    check({tag, "_crst"}, 64'(cnt_rst_o), 64'd0);
    check({tag, "_busy"}, 64'(busy_o), 64'd0);
    check({tag, "_valid"}, 64'(sample_valid_o), 64'd0);
    check({tag, "_last"}, 64'(last_o), 64'd0);
    check({tag, "_min"}, 64'(min_o), 64'hFFFF_FFFF);
    check({tag, "_max"}, 64'(max_o), 64'd0);
    check({tag, "_sum"}, 64'(sum_o), 64'd0);
    check({tag, "_samples"}, 64'(samples_o), 64'd0);
    check({tag, "_abandon"}, 64'(abandon_o), 64'd0);
    check({tag, "_ovf"}, 64'(overflow_o), 64'd0);
  endtask

  initial begin
    tbl[0] = '{K_NORM,   32'd40, 32'd40, 32'd40, 32'd40, 48'd40,
               16'd1, 16'd0, 1'b0};
    tbl[1] = '{K_NORM,   32'd12, 32'd12, 32'd12, 32'd40, 48'd52,
               16'd2, 16'd0, 1'b0};
    tbl[2] = '{K_NORM,   32'd90, 32'd90, 32'd12, 32'd90, 48'd142,
               16'd3, 16'd0, 1'b0};
    tbl[3] = '{K_ABAN,   32'd0,  32'd90, 32'd12, 32'd90, 48'd142,
               16'd3, 16'd1, 1'b0};
    tbl[4] = '{K_OVF,    32'd0,  32'd90, 32'd12, 32'd90, 48'd142,
               16'd3, 16'd1, 1'b1};
    tbl[5] = '{K_CLEAR,  32'd0,  32'd0, 32'hFFFF_FFFF, 32'd0, 48'd0,
               16'd0, 16'd0, 1'b0};
    tbl[6] = '{K_CLRCAP, 32'd77, 32'd0, 32'hFFFF_FFFF, 32'd0, 48'd0,
               16'd0, 16'd0, 1'b0};
    tbl[7] = '{K_NORM,   32'd33, 32'd33, 32'd33, 32'd33, 48'd33,
               16'd1, 16'd0, 1'b0};

    rst_ni = 1'b0; enable = 1'b0; src_sel = 5'd5; pend = '0;
    claim_valid = 1'b0; claim_id = '0; clear = 1'b0; cval = '0;
    settle(3);
    check_reset_vals("reset");
    rst_ni = 1'b1;
    enable = 1'b1;
    settle(4);

    for (int i = 0; i < 8; i++) begin
      run_meas(tbl[i].kind, tbl[i].val);
      check($sformatf("row%0d_last", i), 64'(last_o),
            64'(tbl[i].e_last));
      check($sformatf("row%0d_min", i), 64'(min_o),
            64'(tbl[i].e_min));
      check($sformatf("row%0d_max", i), 64'(max_o),
            64'(tbl[i].e_max));
      check($sformatf("row%0d_sum", i), 64'(sum_o),
            64'(tbl[i].e_sum));
      check($sformatf("row%0d_samples", i), 64'(samples_o),
            64'(tbl[i].e_smp));
      check($sformatf("row%0d_abandon", i), 64'(abandon_o),
            64'(tbl[i].e_ab));
      check($sformatf("row%0d_ovf", i), 64'(overflow_o),
            64'(tbl[i].e_ovf));
      check($sformatf("row%0d_idle", i), 64'(busy_o), 64'd0);
    end

    // Disable in the middle of a measurement.
    pend[5] = 1'b1;
    wait_start();
    enable = 1'b0;
    @(negedge clk);
    check("dis_rst_pulse", 64'(cnt_rst_o), 64'd1);
    check("dis_busy", 64'(busy_o), 64'd0);
    pend[5] = 1'b0;
    @(negedge clk);
    check("dis_rst_once", 64'(cnt_rst_o), 64'd0);
    pend[5] = 1'b1;
    settle(3);
    check("dis_idle_no_start", 64'(cnt_start_o), 64'd0);
    check("dis_abandon", 64'(abandon_o), 64'd0);
    check("dis_samples", 64'(samples_o), 64'd1);
    pend[5] = 1'b0;
    enable = 1'b1;
    settle(4);

    // Saturation of sum and sample count.
    force dut.u_stats.sum_q = 48'hFFFF_FFFF_FFF6;
    force dut.u_stats.samples_q = 16'hFFFF;
    @(negedge clk);
    release dut.u_stats.sum_q;
    release dut.u_stats.samples_q;
    @(negedge clk);
    run_meas(K_NORM, 32'd50);
    check("sat_sum", 64'(sum_o), 64'hFFFF_FFFF_FFFF);
    check("sat_samples", 64'(samples_o), 64'hFFFF);
    check("sat_last", 64'(last_o), 64'd50);
    check("sat_min", 64'(min_o), 64'd33);
    check("sat_max", 64'(max_o), 64'd50);

    // Reset while in STOP.
    pend[5] = 1'b1;
    wait_start();
    claim_valid = 1'b1; claim_id = 5'd5; cval = 32'd60;
    @(negedge clk);
    claim_valid = 1'b0;
    check("stop_reached", 64'(cnt_stop_o), 64'd1);
    rst_ni = 1'b0;
    @(negedge clk);
    check_reset_vals("midstop");
    rst_ni = 1'b1; pend[5] = 1'b0; cval = '0;
    settle(3);
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
